// File: rtl/fsm_step_sequencer.sv
// Script-driven stepping controller: replays {exp_out, sw} entries into a puzzle FSM and scores its out.
// Optional feature macro FSM_SEQ_STATE_CHECK_EN adds fsm_state/state_err and an exp_state field per entry.
module fsm_step_sequencer #(
    parameter int DEPTH  = 16,
    parameter int SW_W   = 2,
    parameter int ST_W   = 3,
    parameter int SETTLE = 1,
    localparam int AW    = $clog2(DEPTH),
`ifdef FSM_SEQ_STATE_CHECK_EN
    localparam int DW    = ST_W + SW_W + 1
`else
    localparam int DW    = SW_W + 1
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic [AW:0]     len,
    input  logic            start,
    input  logic            abort,
    input  logic            fsm_out,
`ifdef FSM_SEQ_STATE_CHECK_EN
    input  logic [ST_W-1:0] fsm_state,
    output logic            state_err,
`endif
    output logic [SW_W-1:0] fsm_sw,
    output logic            fsm_ctrl,
    output logic            busy,
    output logic            done,
    output logic [AW:0]     err_cnt,
    output logic [AW-1:0]   first_err,
    output logic            pass,
    output logic [2:0]      dbg_state
);
    localparam int AW1 = AW + 1;
    localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (SETTLE < 1) || (SW_W < 1) || (ST_W < 1)) begin : g_bad_cfg
        $error("fsm_step_sequencer: unsupported parameter set");
    end

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STEP, S_CHECK, S_FIN} state_t;

    state_t          r_state;
    logic [DW-1:0]   r_ram [DEPTH];
    logic [AW-1:0]   r_idx;
    logic [AW:0]     r_len;
    logic [CW-1:0]   r_settle;
    logic [SW_W-1:0] r_fsm_sw;
    logic            r_fsm_ctrl;
    logic            r_busy;
    logic            r_done;
    logic [AW:0]     r_err_cnt;
    logic [AW-1:0]   r_first_err;
    logic            r_pass;

    logic [AW-1:0]   w_idx_next;
    logic [AW:0]     w_len_clamped;
    logic            w_last;
    logic            w_step_err;

    assign w_idx_next    = r_idx + AW'(1);
    assign w_len_clamped = (len > AW1'(DEPTH)) ? AW1'(DEPTH) : len;
    assign w_last        = ({1'b0, r_idx} == (r_len - AW1'(1)));

`ifdef FSM_SEQ_STATE_CHECK_EN
    logic w_state_err;
    logic r_state_err;
    assign w_state_err = (fsm_state != r_ram[r_idx][SW_W+1 +: ST_W]);
    assign w_step_err  = (fsm_out != r_ram[r_idx][SW_W]) || w_state_err;
    assign state_err   = r_state_err;
`else
    assign w_step_err  = (fsm_out != r_ram[r_idx][SW_W]);
`endif

    // Script RAM has no reset; writes are dropped for the whole run, including its FIN cycle.
    always_ff @(posedge clk) begin
        if (wr_en && !r_busy) begin
            r_ram[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_len       <= '0;
            r_settle    <= '0;
            r_fsm_sw    <= '0;
            r_fsm_ctrl  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '1;
            r_pass      <= 1'b0;
`ifdef FSM_SEQ_STATE_CHECK_EN
            r_state_err <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (abort && (r_state != S_IDLE)) begin
                // Partial err_cnt/first_err are kept so the host can inspect the aborted run.
                r_state    <= S_IDLE;
                r_fsm_ctrl <= 1'b0;
                r_busy     <= 1'b0;
                r_pass     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            r_idx       <= '0;
                            r_len       <= w_len_clamped;
                            r_err_cnt   <= '0;
                            r_first_err <= '1;
                            r_pass      <= 1'b0;
`ifdef FSM_SEQ_STATE_CHECK_EN
                            r_state_err <= 1'b0;
`endif
                            if (w_len_clamped == '0) begin
                                r_done  <= 1'b1;
                                r_state <= S_FIN;
                            end else begin
                                r_busy   <= 1'b1;
                                r_fsm_sw <= r_ram[0][SW_W-1:0];
                                r_settle <= '0;
                                r_state  <= S_SETUP;
                            end
                        end
                    end
                    S_SETUP: begin
                        if (r_settle == CW'(SETTLE - 1)) begin
                            r_fsm_ctrl <= 1'b1;
                            r_state    <= S_STEP;
                        end else begin
                            r_settle <= r_settle + CW'(1);
                        end
                    end
                    S_STEP: begin
                        r_fsm_ctrl <= 1'b0;
                        r_state    <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (w_step_err) begin
                            r_err_cnt <= r_err_cnt + AW1'(1);
                            if (r_err_cnt == '0) begin
                                r_first_err <= r_idx;
                            end
                        end
`ifdef FSM_SEQ_STATE_CHECK_EN
                        if (w_state_err) begin
                            r_state_err <= 1'b1;
                        end
`endif
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_idx    <= w_idx_next;
                            r_fsm_sw <= r_ram[w_idx_next][SW_W-1:0];
                            r_settle <= '0;
                            r_state  <= S_SETUP;
                        end
                    end
                    S_FIN: begin
                        r_busy  <= 1'b0;
                        r_pass  <= (r_err_cnt == '0) && (r_len != '0);
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // abort also kills a ctrl pulse already on the wire this cycle.
    assign fsm_ctrl  = r_fsm_ctrl & ~abort;
    assign fsm_sw    = r_fsm_sw;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err_cnt   = r_err_cnt;
    assign first_err = r_first_err;
    assign pass      = r_pass;
    assign dbg_state = r_state;
endmodule
